// File: rtl/tcdm_initiator.sv
// rtl/tcdm_initiator.sv - core-side TCDM initiator with in-order response reorder buffer
// Optional LR wait: define TCDM_INITIATOR_LRWAIT_EN to block all requests behind an outstanding LR.
module tcdm_initiator #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CoreIdWidth    = 8,
  parameter int unsigned TileIdWidth    = 4,
  parameter int unsigned IniAddrWidth   = 3,
  parameter int unsigned IdWidth        = $clog2(MaxOutstanding)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [CoreIdWidth-1:0]  core_id_i,
  input  logic [TileIdWidth-1:0]  tile_id_i,
  input  logic [IniAddrWidth-1:0] ini_addr_i,
  input  logic                    core_req_valid_i,
  output logic                    core_req_ready_o,
  input  logic [AddrWidth-1:0]    core_req_addr_i,
  input  logic                    core_req_write_i,
  input  logic [3:0]              core_req_amo_i,
  input  logic [DataWidth-1:0]    core_req_wdata_i,
  input  logic [DataWidth/8-1:0]  core_req_be_i,
  output logic                    core_resp_valid_o,
  input  logic                    core_resp_ready_i,
  output logic [DataWidth-1:0]    core_resp_rdata_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [AddrWidth-1:0]    out_addr_o,
  output logic                    out_write_o,
  output logic [3:0]              out_amo_o,
  output logic [DataWidth-1:0]    out_wdata_o,
  output logic [DataWidth/8-1:0]  out_be_o,
  output logic [IniAddrWidth+TileIdWidth+CoreIdWidth+IdWidth-1:0] out_meta_o,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DataWidth-1:0]    in_rdata_i,
  input  logic [IdWidth-1:0]      in_id_i
);

  if (DataWidth != 32) begin : gen_dw_check
    $error("tcdm_initiator: only DataWidth = 32 is supported");
  end
  if (MaxOutstanding < 2 || (MaxOutstanding & (MaxOutstanding - 1)) != 0) begin : gen_rob_check
    $error("tcdm_initiator: MaxOutstanding must be a power of two >= 2");
  end

  localparam int unsigned CntWidth = IdWidth + 1;
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [IdWidth-1:0]  IdOne  = IdWidth'(1);

  logic [MaxOutstanding-1:0] busy_q, done_q;
  logic [DataWidth-1:0]      data_q [MaxOutstanding];
  logic [IdWidth-1:0]        head_q, tail_q;
  logic [CntWidth-1:0]       count_q;
  logic                      lr_stall;
  logic                      tracked, can_issue, alloc, retire;

  assign tracked          = !core_req_write_i;
  assign can_issue        = !lr_stall && (!tracked || count_q < MaxCnt);
  assign out_valid_o      = core_req_valid_i && can_issue;
  assign core_req_ready_o = out_ready_i && can_issue;
  assign alloc            = out_valid_o && out_ready_i && tracked;

  assign out_addr_o  = core_req_addr_i;
  assign out_write_o = core_req_write_i;
  assign out_amo_o   = core_req_amo_i;
  assign out_wdata_o = core_req_wdata_i;
  assign out_be_o    = core_req_be_i;
  // Stores never get a response, so their id field carries no meaning.
  assign out_meta_o  = {ini_addr_i, tile_id_i, core_id_i, tracked ? tail_q : {IdWidth{1'b0}}};

  // Every tracked request owns its slot before issue, so responses are never refused.
  assign in_ready_o        = 1'b1;
  assign core_resp_valid_o = busy_q[head_q] && done_q[head_q];
  assign core_resp_rdata_o = data_q[head_q];
  assign retire            = core_resp_valid_o && core_resp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      for (int i = 0; i < MaxOutstanding; i++) data_q[i] <= '0;
    end else begin
      if (alloc) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + IdOne;
      end
      if (in_valid_i) begin
        done_q[in_id_i] <= 1'b1;
        data_q[in_id_i] <= in_rdata_i;
      end
      if (retire) begin
        busy_q[head_q] <= 1'b0;
        head_q         <= head_q + IdOne;
      end
      case ({alloc, retire})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: ;
      endcase
    end
  end

`ifdef TCDM_INITIATOR_LRWAIT_EN
  logic               lr_stall_q;
  logic [IdWidth-1:0] lr_id_q;

  // The bank may park an LR behind another core's SC, so nothing may overtake it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lr_stall_q <= 1'b0;
      lr_id_q    <= '0;
    end else if (alloc && core_req_amo_i == 4'hA) begin
      lr_stall_q <= 1'b1;
      lr_id_q    <= tail_q;
    end else if (retire && head_q == lr_id_q) begin
      lr_stall_q <= 1'b0;
    end
  end
  assign lr_stall = lr_stall_q;
`else
  assign lr_stall = 1'b0;
`endif

  resp_to_live_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    in_valid_i |-> (busy_q[in_id_i] && !done_q[in_id_i]));

endmodule

// File: tb/tb_tcdm_initiator.sv
// tb/tb_tcdm_initiator.sv - scoreboard bench for tcdm_initiator
module tb_tcdm_initiator;
  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  core_id  = 8'h5A;
  logic [3:0]  tile_id  = 4'h9;
  logic [2:0]  ini_addr = 3'h5;
  logic        core_req_valid, core_req_ready, core_req_write;
  logic [31:0] core_req_addr, core_req_wdata;
  logic [3:0]  core_req_amo, core_req_be;
  logic        core_resp_valid, core_resp_ready;
  logic [31:0] core_resp_rdata;
  logic        out_valid, out_ready, out_write;
  logic [31:0] out_addr, out_wdata;
  logic [3:0]  out_amo, out_be;
  logic [16:0] out_meta;
  logic        in_valid, in_ready;
  logic [31:0] in_rdata;
  logic [1:0]  in_id;

  always #5 clk = ~clk;

  tcdm_initiator dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_id_i(core_id), .tile_id_i(tile_id), .ini_addr_i(ini_addr),
    .core_req_valid_i(core_req_valid), .core_req_ready_o(core_req_ready),
    .core_req_addr_i(core_req_addr), .core_req_write_i(core_req_write),
    .core_req_amo_i(core_req_amo), .core_req_wdata_i(core_req_wdata), .core_req_be_i(core_req_be),
    .core_resp_valid_o(core_resp_valid), .core_resp_ready_i(core_resp_ready),
    .core_resp_rdata_o(core_resp_rdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_addr_o(out_addr),
    .out_write_o(out_write), .out_amo_o(out_amo), .out_wdata_o(out_wdata), .out_be_o(out_be),
    .out_meta_o(out_meta),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_rdata_i(in_rdata), .in_id_i(in_id)
  );

  // Reference model: tracked requests in issue order, each filled in when its response arrives.
  typedef struct {
    int          id;
    bit          done;
    logic [31:0] data;
    bit          is_lr;
  } ent_t;

  ent_t exp_q[$];
  int   pend_q[$];
  int   tracked_cnt;
  bit   lr_model;
  bit   req_fired;
  int   vectors, miscompares;

  bit   m_valid, m_can, m_fire, m_found;
  logic [1:0] m_id;
  ent_t m_ent;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pend_q.delete();
      tracked_cnt = 0;
      lr_model    = 1'b0;
      req_fired   = 1'b0;
      check("rst_resp_valid", core_resp_valid, 0);
      check("rst_resp_rdata", core_resp_rdata, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
    end else begin
      m_valid = exp_q.size() > 0 && exp_q[0].done;
      m_can   = !lr_model && (core_req_write || exp_q.size() < MAX);
      m_fire  = core_req_valid && out_ready && m_can;
      m_id    = core_req_write ? 2'd0 : 2'(tracked_cnt % MAX);
      check("resp_valid", core_resp_valid, m_valid);
      if (m_valid) check("resp_rdata", core_resp_rdata, exp_q[0].data);
      check("out_valid", out_valid, core_req_valid && m_can);
      check("req_ready", core_req_ready, out_ready && m_can);
      check("in_ready", in_ready, 1);
      if (out_valid) begin
        check("out_addr_wdata", {out_addr, out_wdata}, {core_req_addr, core_req_wdata});
        check("out_ctrl", {out_write, out_amo, out_be}, {core_req_write, core_req_amo, core_req_be});
        check("out_meta", out_meta, {ini_addr, tile_id, core_id, m_id});
      end
      req_fired = m_fire;
      if (m_valid && core_resp_ready) begin
        if (exp_q[0].is_lr) lr_model = 1'b0;
        void'(exp_q.pop_front());
      end
      if (in_valid) begin
        m_found = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!m_found && exp_q[i].id == int'(in_id) && !exp_q[i].done) begin
            exp_q[i].done = 1'b1;
            exp_q[i].data = in_rdata;
            m_found = 1'b1;
          end
        end
        check("resp_id_live", m_found, 1);
      end
      if (m_fire && !core_req_write) begin
        m_ent.id    = tracked_cnt % MAX;
        m_ent.done  = 1'b0;
        m_ent.data  = '0;
        m_ent.is_lr = 1'b0;
`ifdef TCDM_INITIATOR_LRWAIT_EN
        if (core_req_amo == 4'hA) begin
          m_ent.is_lr = 1'b1;
          lr_model    = 1'b1;
        end
`endif
        exp_q.push_back(m_ent);
        pend_q.push_back(m_ent.id);
        tracked_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input bit w, input logic [3:0] amo,
                         input logic [31:0] wd, input logic [3:0] be);
    core_req_valid = 1'b1;
    core_req_addr  = a;
    core_req_write = w;
    core_req_amo   = amo;
    core_req_wdata = wd;
    core_req_be    = be;
  endtask

  task automatic issue(input logic [31:0] a, input bit w, input logic [3:0] amo);
    int n;
    n = 0;
    set_req(a, w, amo, $urandom(), 4'($urandom_range(15)));
    step();
    while (!req_fired && n < 40) begin
      step();
      n++;
    end
    check("issue_within_bound", req_fired, 1);
    core_req_valid = 1'b0;
  endtask

  task automatic respond(input int id, input logic [31:0] data);
    for (int i = 0; i < pend_q.size(); i++)
      if (pend_q[i] == id) begin
        pend_q.delete(i);
        break;
      end
    in_valid = 1'b1;
    in_id    = 2'(id);
    in_rdata = data;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    int k;
    n = 0;
    core_req_valid  = 1'b0;
    core_resp_ready = 1'b1;
    while ((exp_q.size() > 0 || pend_q.size() > 0) && n < 300) begin
      in_valid = 1'b0;
      if (pend_q.size() > 0) begin
        k = $urandom_range(pend_q.size() - 1);
        in_valid = 1'b1;
        in_id    = 2'(pend_q[k]);
        in_rdata = $urandom();
        pend_q.delete(k);
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    step();
    step();
  endtask

  task automatic pulse_reset();
    rst_n          = 1'b0;
    core_req_valid = 1'b0;
    in_valid       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int a, b;
    int k;
    vectors = 0;
    miscompares = 0;
    core_req_valid = 0; core_req_addr = 0; core_req_write = 0; core_req_amo = 0;
    core_req_wdata = 0; core_req_be = 0; core_resp_ready = 1; out_ready = 1;
    in_valid = 0; in_rdata = 0; in_id = 0;
    rst_n = 1'b0;
    step();
    pulse_reset();

    // Out-of-order responses come back in issue order.
    issue(32'h10, 0, 4'h0);
    issue(32'h14, 0, 4'h0);
    respond(1, 32'hBBBB);
    respond(0, 32'hAAAA);
    repeat (4) step();

    // Full ROB: fifth load stalls, store passes, load goes after a retirement.
    for (int i = 0; i < 4; i++) issue(32'h200 + 32'(4 * i), 0, 4'h0);
    set_req(32'h210, 0, 4'h0, 0, 4'hF);
    repeat (3) step();
    core_req_valid = 1'b0;
    issue(32'h100, 1, 4'h0);
    fork
      begin repeat (2) step(); respond(pend_q[0], 32'h1234_5678); end
      issue(32'h210, 0, 4'h0);
    join

    // Back-pressure on the core response port with three entries done.
    core_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) respond(pend_q[pend_q.size() - 1], $urandom());
    repeat (10) step();
    core_resp_ready = 1'b1;
    repeat (5) step();
    drain();

    // LR followed by a load and a store.
    issue(32'h40, 0, 4'hA);
    fork
      begin repeat (4) step(); respond(pend_q[0], 32'h0000_0040); end
      begin issue(32'h80, 0, 4'h0); issue(32'h84, 1, 4'h0); end
    join
    drain();

    // AMO add and SC each hold an entry; SC result forwarded unchanged.
    issue(32'h300, 0, 4'h1);
    issue(32'h304, 0, 4'hB);
    a = pend_q[0];
    b = pend_q[1];
    respond(b, 32'h1);
    respond(a, 32'hDEAD_0007);
    repeat (3) step();
    issue(32'h308, 0, 4'hB);
    respond(pend_q[0], 32'h0);
    repeat (3) step();

    // Reset with two entries outstanding; next load must restart at id 0.
    issue(32'h400, 0, 4'h0);
    issue(32'h404, 0, 4'h0);
    pulse_reset();
    issue(32'h408, 0, 4'h0);
    drain();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      out_ready       = ($urandom_range(3) != 0);
      core_resp_ready = ($urandom_range(9) < 7);
      in_valid        = 1'b0;
      if (pend_q.size() > 0 && $urandom_range(1) == 1) begin
        k = $urandom_range(pend_q.size() - 1);
        in_valid = 1'b1;
        in_id    = 2'(pend_q[k]);
        in_rdata = $urandom();
        pend_q.delete(k);
      end
      if (core_req_valid && req_fired) core_req_valid = 1'b0;
      if (!core_req_valid && $urandom_range(9) < 7) begin
        if ($urandom_range(9) < 3) set_req($urandom(), 1, 4'h0, $urandom(), 4'($urandom_range(15)));
        else set_req($urandom(), 0, 4'($urandom_range(11)), $urandom(), 4'($urandom_range(15)));
      end
      step();
    end
    out_ready = 1'b1;
    if (core_req_valid) begin
      k = 0;
      while (!req_fired && k < 40) begin
        in_valid = 1'b0;
        if (pend_q.size() > 0) begin
          in_valid = 1'b1;
          in_id    = 2'(pend_q[0]);
          in_rdata = $urandom();
          void'(pend_q.pop_front());
        end
        core_resp_ready = 1'b1;
        step();
        k++;
      end
      check("final_req_bound", req_fired, 1);
      core_req_valid = 1'b0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

endmodule

// File: doc/tcdm_initiator.md
# tcdm_initiator

Core-side initiator for the tile's TCDM request/response protocol; the counterpart of the bank-side adapter that serves loads, stores, AMOs and LR/SC. Converts a core's in-order memory requests into valid/ready TCDM requests tagged with routing metadata and a transaction ID. Returns out-of-order bank responses to the core strictly in issue order through a small reorder buffer (ROB). Sits between the core's data port and the tile/group request interconnect.

## Interface
- AddrWidth, 32, address width
- DataWidth, 32, data width; only 32 supported (elaboration error otherwise)
- MaxOutstanding, 4, ROB depth; power of two, >= 2
- CoreIdWidth, 8, width of core_id field
- TileIdWidth, 4, width of tile_id field
- IniAddrWidth, 3, width of ini_addr field
- IdWidth, $clog2(MaxOutstanding), derived, do not override

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- core_id_i / tile_id_i / ini_addr_i  in  CoreIdWidth/TileIdWidth/IniAddrWidth  static identity, copied into every request's metadata
- core_req_valid_i / core_req_ready_o  in/out  1  core request handshake
- core_req_addr_i  in  AddrWidth  address
- core_req_write_i  in  1  1 = store, 0 = load/AMO/LR/SC
- core_req_amo_i  in  4  AMO code (0 none, 1-9 arithmetic, A = LR, B = SC)
- core_req_wdata_i / core_req_be_i  in  DataWidth / DataWidth/8  write data, byte enable
- core_resp_valid_o / core_resp_ready_i  out/in  1  core response handshake
- core_resp_rdata_o  out  DataWidth  response data
- out_valid_o / out_ready_i  out/in  1  TCDM request handshake
- out_addr_o, out_write_o, out_amo_o, out_wdata_o, out_be_o  out  as core side  forwarded request fields
- out_meta_o  out  IniAddrWidth+TileIdWidth+CoreIdWidth+IdWidth  {ini_addr, tile_id, core_id, id}
- in_valid_i / in_ready_o  in/out  1  TCDM response handshake
- in_rdata_i  in  DataWidth  response data
- in_id_i  in  IdWidth  id field of returned metadata

## Operation
- Request is "tracked" iff core_req_write_i = 0 (loads, AMOs, LR, SC); stores are untracked (no response exists).
- can_issue = !lr_stall && (untracked || count_q < MaxOutstanding).
- out_valid_o = core_req_valid_i && can_issue; core_req_ready_o = out_ready_i && can_issue. Fields pass through combinationally.
- out_meta_o.id = tail_q for tracked requests; 0 for stores (ignored by responder).
- Handshake of a tracked request: ROB[tail_q].busy <= 1, .done <= 0; tail_q <= tail_q + 1 (mod MaxOutstanding); count_q + 1.
- in_ready_o is constant 1 (slot pre-reserved). Response: ROB[in_id_i].data <= in_rdata_i, .done <= 1.
- core_resp_valid_o = ROB[head_q].busy && ROB[head_q].done; data from ROB[head_q].data. On core handshake: busy <= 0, head_q + 1, count_q - 1.
- Allocation and retirement in the same cycle: count_q unchanged. Freed slot is not usable for allocation in its retire cycle (ready does not depend on core_resp_ready_i).
- Response and retirement of the same entry in one cycle impossible (done must be registered first).
- Response to a non-busy or already-done slot: protocol violation, assertion fires; state update still performed.

## Timing
- Reset: head_q = tail_q = count_q = 0, all busy/done = 0, lr_stall = 0; core_resp_valid_o = 0, out_valid_o = 0 (core_req_valid_i low assumed at reset, combinational otherwise), in_ready_o = 1, core_resp_rdata_o = 0.
- Request path: zero latency, combinational.
- Response path: in_valid_i at cycle N -> core_resp_valid_o earliest at N+1, if entry is at head.
- Responses held indefinitely while core_resp_ready_i = 0; no loss, in-order.
- Full (count_q = MaxOutstanding): tracked requests stall, stores proceed.
- Reset mid-operation: all outstanding entries discarded; late responses after reset are violations.

## Configuration
- TCDM_INITIATOR_LRWAIT_EN defined: handshake of an LR (amo = A) sets lr_stall; all subsequent requests (including stores) stall until that LR's entry retires to the core, then lr_stall clears in the retire cycle+1. Required because bank may hold LR response until a preceding reservation's SC completes.
- Undefined: LR treated as an ordinary tracked load; lr_stall tied to 0.

## Test plan
- Load A (id 0), load B (id 1); responses return id 1 (0xBBBB) then id 0 (0xAAAA) -> core sees 0xAAAA then 0xBBBB, each one cycle after the later of response/ordering.
- 4 tracked loads outstanding, 5th load held (core_req_ready_o = 0), store to 0x100 issued same cycle -> store passes; 5th load issues the cycle after first retirement.
- core_resp_ready_i low for 10 cycles with 3 done entries -> no data lost, 3 responses returned in order once ready rises.
- LRWAIT_EN: LR 0x40 issued, load 0x80 and store 0x84 presented -> both stall until LR response retires; without macro both issue back-to-back.
- AMOAdd (write=0) and SC -> each allocates an entry; SC response 0/1 forwarded unchanged.
- Reset asserted with 2 entries outstanding -> core_resp_valid_o = 0, count 0, next request gets id 0.
